instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter bits, default 32: address width in bits.
REQ-002 Parameter isize, default 2: log2 of instruction width in 8-bit bytes, so instruction width is 8<<isize bits.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ip_addr  input  bits  current instruction pointer value.
REQ-006 ip_incr  output  1  one-cycle pulse that advances the instruction pointer by one instruction.
REQ-007 redirect  input  1  jump taken this cycle; the pointer loads its jump address on the same edge.
REQ-008 mem_req_valid  output  1  read request valid.
REQ-009 mem_req_ready  input  1  memory accepts the request.
REQ-010 mem_req_addr  output  bits  read address.
REQ-011 mem_rsp_valid  input  1  read data valid; responses are in order and cannot be stalled.
REQ-012 mem_rsp_data  input  8<<isize  read data.
REQ-013 inst_valid  output  1  fetched instruction available.
REQ-014 inst_ready  input  1  consumer takes the instruction.
REQ-015 inst_data  output  8<<isize  instruction word.
REQ-016 inst_addr  output  bits  address the instruction was fetched from.

Function
REQ-017 The block SHALL hold three counters, each 0..2: pending (requests accepted, response not yet received), drop (the subset of pending to be discarded), and buffered (entries in a 2-entry instruction FIFO).
REQ-018 mem_req_valid SHALL be 1 iff redirect=0 and (pending - drop) + buffered < 2; mem_req_addr SHALL equal ip_addr.
REQ-019 A request is accepted on a cycle with mem_req_valid=1 and mem_req_ready=1; on that cycle ip_incr SHALL be 1, otherwise ip_incr SHALL be 0.
REQ-020 ip_incr SHALL never be 1 while redirect=1.
REQ-021 On acceptance, mem_req_addr SHALL be pushed into a 2-entry in-order address queue and pending SHALL increment.
REQ-022 On mem_rsp_valid=1 with drop>0, pending and drop SHALL each decrement, the head address SHALL be popped, and the data SHALL be discarded.
REQ-023 On mem_rsp_valid=1 with drop=0 and pending>0, the data and the popped head address SHALL be written to the instruction FIFO, and pending SHALL decrement.
REQ-024 The credit rule in REQ-018 SHALL guarantee that the FIFO never overflows; the bench SHALL flag any overflow as an error.
REQ-025 A response arriving while pending=0 SHALL be ignored with no state change.
REQ-026 inst_valid SHALL be 1 iff buffered>0; inst_data and inst_addr SHALL show the FIFO head; the head SHALL pop when inst_valid=1 and inst_ready=1.
REQ-027 FIFO push and pop in the same cycle SHALL leave buffered unchanged, including when buffered=2.
REQ-028 A response written with buffered=0 SHALL appear on inst_valid in the next cycle, giving 1-cycle latency from response to instruction.
REQ-029 On redirect=1: the FIFO SHALL be cleared (buffered<=0), any response in that cycle SHALL be discarded, and drop SHALL be set to pending minus 1 if mem_rsp_valid=1, otherwise to pending.
REQ-030 Redirect SHALL take priority over every simultaneous event, including inst_ready, a response, or mem_req_ready.
REQ-031 A redirect on consecutive cycles SHALL be handled the same way each cycle.
REQ-032 The address queue pointers SHALL wrap modulo 2.

Reset
REQ-033 While rst=1 at a clock edge, pending, drop, buffered and all queue pointers SHALL be set to 0.
REQ-034 During reset, mem_req_valid, ip_incr and inst_valid SHALL be 0.
REQ-035 inst_data, inst_addr and mem_req_addr are don't-care while their valid signals are 0.
REQ-036 A reset in the middle of operation SHALL abandon all in-flight responses; the memory is reset at the same time.
REQ-037 rst SHALL take priority over redirect.

Verification
REQ-038 Reset with ip_addr=0x0: mem_req_valid=0 and inst_valid=0 during reset; in the first cycle after reset, mem_req_valid=1 with mem_req_addr=0x0.
REQ-039 ready=1 always, memory latency 1, pointer stepping by 4 from 0x100: the output stream is 0x100, 0x104, 0x108, ... with data matching, and no more than 2 requests outstanding at any time.
REQ-040 inst_ready=0 after two responses: mem_req_valid stays 0, the FIFO holds 0x100 and 0x104, and ip_incr stays 0.
REQ-041 Redirect to 0x200 with 2 pending: both late responses are dropped, and the next instruction delivered is from 0x200.
REQ-042 Redirect coincident with a response and inst_ready=1: the response is discarded, inst_valid=0 in the next cycle, and drop equals pending minus 1.
REQ-043 Random stalls on mem_req_ready and inst_ready, random latency 1-4: delivered addresses are strictly sequential between redirects, with no loss or duplication.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues reads at the instruction pointer and
// buffers in-order responses in a 2-entry FIFO, dropping stale ones.
module instruction_fetch #(
    parameter int bits  = 32,
    parameter int isize = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [bits-1:0]       ip_addr,
    output logic                  ip_incr,
    input  logic                  redirect,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [bits-1:0]       mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [(8<<isize)-1:0] mem_rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [(8<<isize)-1:0] inst_data,
    output logic [bits-1:0]       inst_addr
);
    localparam int IW = 8 << isize;

    logic [1:0]      pend_q, pend_d;
    logic [1:0]      drop_q, drop_d;
    logic [1:0]      buf_q, buf_d;
    logic            aq_wr_q, aq_wr_d;
    logic            aq_rd_q, aq_rd_d;
    logic            fw_q, fw_d;
    logic            fr_q, fr_d;
    logic [bits-1:0] aq_q [2];
    logic [IW-1:0]   fd_q [2];
    logic [bits-1:0] fa_q [2];

    logic [2:0] credit;
    logic       rsp_take;
    logic       accept;
    logic       push;
    logic       pop;

    assign inst_valid   = !rst && (buf_q != 2'd0);
    assign inst_data    = fd_q[fr_q];
    assign inst_addr    = fa_q[fr_q];
    assign mem_req_addr = ip_addr;
    assign ip_incr      = accept;

    // Credit check, event decode and next-state counters/pointers.
    always_comb begin
        credit   = {1'b0, pend_q - drop_q} + {1'b0, buf_q};
        rsp_take = mem_rsp_valid && (pend_q != 2'd0);
        // With two requests in flight (all marked for drop) a new
        // request may only go out when one of them retires now, so
        // pending and the address queue never exceed two entries.
        mem_req_valid = !rst && !redirect
                        && (credit < 3'd2)
                        && ((pend_q != 2'd2) || rsp_take);
        accept = mem_req_valid && mem_req_ready;
        push   = rsp_take && (drop_q == 2'd0) && !redirect;
        pop    = inst_valid && inst_ready && !redirect;

        pend_d  = pend_q + {1'b0, accept} - {1'b0, rsp_take};
        drop_d  = drop_q;
        buf_d   = buf_q;
        aq_wr_d = aq_wr_q ^ accept;
        aq_rd_d = aq_rd_q ^ rsp_take;
        fw_d    = fw_q;
        fr_d    = fr_q;

        if (redirect) begin
            drop_d = pend_q - {1'b0, rsp_take};
            buf_d  = 2'd0;
            fw_d   = 1'b0;
            fr_d   = 1'b0;
        end else begin
            if (rsp_take && (drop_q != 2'd0)) begin
                drop_d = drop_q - 2'd1;
            end
            buf_d = buf_q + {1'b0, push} - {1'b0, pop};
            fw_d  = fw_q ^ push;
            fr_d  = fr_q ^ pop;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= 2'd0;
            drop_q  <= 2'd0;
            buf_q   <= 2'd0;
            aq_wr_q <= 1'b0;
            aq_rd_q <= 1'b0;
            fw_q    <= 1'b0;
            fr_q    <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            buf_q   <= buf_d;
            aq_wr_q <= aq_wr_d;
            aq_rd_q <= aq_rd_d;
            fw_q    <= fw_d;
            fr_q    <= fr_d;
        end
    end

    // Address queue and instruction FIFO storage (no reset needed).
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            aq_q[aq_wr_q] <= ip_addr;
        end
        if (!rst && push) begin
            fd_q[fw_q] <= mem_rsp_data;
            fa_q[fw_q] <= aq_q[aq_rd_q];
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: pointer and memory models drive the DUT,
// a scoreboard queue holds expected fetch addresses for the monitor.
module tb_instruction_fetch;
    logic        clk;
    logic        rst;
    logic [31:0] ip_addr;
    logic        ip_incr;
    logic        redirect;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_addr;

    instruction_fetch dut (
        .clk(clk),
        .rst(rst),
        .ip_addr(ip_addr),
        .ip_incr(ip_incr),
        .redirect(redirect),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_addr(inst_addr)
    );

    typedef struct {
        logic [31:0] a;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] ip;
    logic [31:0] tgt;
    logic [31:0] mon_e;
    int          cyc;
    int          checks;
    int          failures;
    int          n_del;
    int          n0;
    int          max_out;
    int          incr_err;
    int          lat_lo;
    int          lat_hi;
    bit          rdy_rand;
    bit          ir_rand;
    bit          ir_val;
    bit          hold;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return {a[15:0], a[15:0]} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", n, act, exp);
        end
    endtask

    task automatic step();
        bit acc;
        bit rfire;
        int l;
        @(negedge clk);
        acc   = ip_incr;
        rfire = mem_rsp_valid;
        if (ip_incr !== (mem_req_valid && mem_req_ready))
            incr_err++;
        if (redirect && ip_incr)
            incr_err++;
        if (redirect)
            exp_q.delete();
        if (acc && !rst) begin
            l = int'($urandom_range(lat_hi, lat_lo));
            mq.push_back('{ip, cyc + l});
            exp_q.push_back(ip);
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq.delete();
            exp_q.delete();
        end else begin
            if (rfire && mq.size() > 0)
                void'(mq.pop_front());
            if (redirect)
                ip = tgt;
            else if (acc)
                ip = ip + 32'd4;
        end
        if (mq.size() > max_out)
            max_out = mq.size();
        #1;
        ip_addr       = ip;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = dat(mq[0].a);
        end
        redirect = 1'b0;
        if (hold) begin
            mem_req_ready = 1'b0;
            inst_ready    = 1'b1;
        end else begin
            mem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            inst_ready    = ir_rand ? 1'($urandom_range(0, 1)) : ir_val;
        end
    endtask

    task automatic do_reset(input logic [31:0] a);
        rst     = 1'b1;
        ip      = a;
        ip_addr = a;
        hold    = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string n);
        #1;
        for (int k = 0; k < 30; k++) begin
            if (inst_valid) break;
            step();
            #1;
        end
        chk(n, inst_valid, 1);
    endtask

    task automatic drain();
        hold          = 1'b1;
        mem_req_ready = 1'b0;
        inst_ready    = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (exp_q.size() == 0 && mq.size() == 0) break;
            step();
        end
        hold = 1'b0;
        chk("drain_exp_empty", exp_q.size(), 0);
        chk("drain_mem_empty", mq.size(), 0);
    endtask

    // Scoreboard monitor: every consumed instruction must match the
    // oldest surviving fetch address and its memory contents.
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready && !redirect) begin
            checks++;
            n_del++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL inst_unexpected act_addr=%h", inst_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (inst_addr !== mon_e || inst_data !== dat(mon_e)) begin
                    failures++;
                    $display("FAIL inst_stream act=%h/%h exp=%h/%h",
                             inst_addr, inst_data, mon_e, dat(mon_e));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        checks = 0; failures = 0; n_del = 0; cyc = 0;
        max_out = 0; incr_err = 0;
        lat_lo = 1; lat_hi = 1;
        rdy_rand = 0; ir_rand = 0; ir_val = 1; hold = 0;
        rst = 1'b1; redirect = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
        inst_ready = 1'b0; ip = 32'h0; ip_addr = 32'h0; tgt = 32'h0;

        // reset behaviour, ip=0
        step(); #1;
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_ip_incr", ip_incr, 0);
        step();
        rst = 1'b0; #1;
        chk("post_rst_req_valid", mem_req_valid, 1);
        chk("post_rst_req_addr", mem_req_addr, 32'h0);

        // streaming, latency 1, from 0x100
        do_reset(32'h100);
        n0 = n_del;
        step(); step(); #1;
        chk("lat1_inst_valid", inst_valid, 1);
        chk("lat1_inst_addr", inst_addr, 32'h100);
        chk("lat1_inst_data", inst_data, 32'hA4A5_0E0F);
        repeat (30) step();
        drain();
        chk("stream_count_ok", (n_del - n0) >= 15, 1);

        // consumer stalled: FIFO fills and requests stop
        ir_val = 0;
        do_reset(32'h100);
        repeat (6) step();
        #1;
        chk("full_req_valid", mem_req_valid, 0);
        chk("full_ip_incr", ip_incr, 0);
        chk("full_inst_valid", inst_valid, 1);
        chk("full_head_addr", inst_addr, 32'h100);
        chk("full_head_data", inst_data, 32'hA4A5_0E0F);
        inst_ready = 1'b1;
        step(); #1;
        chk("full_next_addr", inst_addr, 32'h104);
        chk("full_next_data", inst_data, 32'hA4A1_0E0B);
        ir_val = 1;
        drain();

        // redirect with two requests pending
        lat_lo = 3; lat_hi = 3;
        do_reset(32'h100);
        step(); step();
        redirect = 1'b1; tgt = 32'h200; #1;
        chk("redir_req_valid", mem_req_valid, 0);
        chk("redir_ip_incr", ip_incr, 0);
        step();
        wait_valid("redir_wait_valid");
        chk("redir_first_addr", inst_addr, 32'h200);
        chk("redir_first_data", inst_data, 32'hA7A5_0D0F);
        drain();

        // redirect coincident with a response and inst_ready
        lat_lo = 2; lat_hi = 2;
        do_reset(32'h100);
        step(); step();
        redirect = 1'b1; tgt = 32'h300; inst_ready = 1'b1;
        step(); #1;
        chk("redir_rsp_inst_valid", inst_valid, 0);
        wait_valid("redir_rsp_wait_valid");
        chk("redir_rsp_addr", inst_addr, 32'h300);
        chk("redir_rsp_data", inst_data, 32'hA6A5_0C0F);
        drain();

        // random stalls, latency 1-4, bursts of redirects
        lat_lo = 1; lat_hi = 4;
        rdy_rand = 1; ir_rand = 1;
        do_reset(32'h1000);
        n0 = n_del;
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(0, 39) == 0) begin
                for (int r = 0; r < int'($urandom_range(1, 3)); r++) begin
                    redirect = 1'b1;
                    tgt = 32'h4000 + 32'($urandom_range(0, 1023)) * 32'd4;
                    step();
                end
            end
        end
        drain();
        chk("rand_flow_ok", (n_del - n0) > 100, 1);
        chk("max_outstanding_ok", max_out <= 2, 1);
        chk("ip_incr_rule_errs", incr_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
